mod_counter: RTL and testbench



---
 rtl/mod_counter.sv | 64 ++++++
 tb/tb_mod_counter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo up-counter (0..max) with synchronous preload and a
//            registered one-cycle wrap pulse; UART receiver bit-timing divider.
//            Optional clock enable port when MOD_COUNTER_CE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic             inc,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] value_to_set,
    input  logic             set_value,
`ifdef MOD_COUNTER_CE_EN
    input  logic             ce,
`endif
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_value;
    logic             r_overflow;
    logic             w_advance;
    logic             w_at_limit;

`ifdef MOD_COUNTER_CE_EN
    assign w_advance = ce;
`else
    assign w_advance = 1'b1;
`endif

    // ">=" rather than "==" so a preload above max still wraps instead of
    // running on to 2^WIDTH.
    assign w_at_limit = (r_value >= max);

    always_ff @(posedge inc or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= c_ZERO;
            r_overflow <= 1'b0;
        end else if (set_value) begin
            r_value    <= value_to_set;
            r_overflow <= 1'b0;
        end else if (!w_advance) begin
            r_overflow <= 1'b0;
        end else if (w_at_limit) begin
            r_value    <= c_ZERO;
            r_overflow <= 1'b1;
        end else begin
            r_value    <= r_value + c_ONE;
            r_overflow <= 1'b0;
        end
    end

    assign value    = r_value;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_counter
// Purpose  : Self-checking bench for mod_counter against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

    localparam int W = 8;

    logic         inc;
    logic         rst_n;
    logic [W-1:0] max;
    logic [W-1:0] value_to_set;
    logic         set_value;
    logic         ce;
    logic [W-1:0] value;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    // Reference state: count as a plain integer, wrap flag as a bit
    int m_v;
    bit m_ov;

    mod_counter #(.WIDTH(W)) dut (
        .inc          (inc),
        .rst_n        (rst_n),
        .max          (max),
        .value_to_set (value_to_set),
        .set_value    (set_value),
`ifdef MOD_COUNTER_CE_EN
        .ce           (ce),
`endif
        .value        (value),
        .overflow     (overflow)
    );

    initial inc = 1'b0;
    always #5 inc = ~inc;

    // One rising edge of inc; model evaluates the rules on the values present at the edge
    task automatic tick();
        int mx;
        @(posedge inc);
        mx = int'(max);
        if (set_value) begin
            m_v = int'(value_to_set); m_ov = 1'b0;
`ifdef MOD_COUNTER_CE_EN
        end else if (!ce) begin
            m_ov = 1'b0;
`endif
        end else if (m_v >= mx) begin
            m_v = 0; m_ov = 1'b1;
        end else begin
            m_v = (m_v + 1) % (1 << W); m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_value = 1'b0; value_to_set = '0; max = 8'd9; ce = 1'b1;
        repeat (3) @(posedge inc);
        #1;
        checks++;
        if (value !== 8'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset: value=%0d ovf=%0b expected value=0 ovf=0", value, overflow);
        end
        rst_n = 1'b1; m_v = 0; m_ov = 1'b0;
    endtask

    task automatic test_period();
        int pulses = 0;
        max = 8'd9;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (value !== W'(i % 10) || overflow !== (i % 10 == 0)) begin
                errors++;
                $display("FAIL period edge %0d: value=%0d ovf=%0b expected value=%0d ovf=%0b",
                         i, value, overflow, i % 10, (i % 10 == 0));
            end
            if (overflow) pulses++;
        end
        checks++;
        if (pulses !== 3) begin
            errors++; $display("FAIL period_pulses: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_preload();
        int edges = 0;
        bit seen = 1'b0;
        // value is 0 here; step to 2
        tick(); tick();
        checks++;
        if (value !== 8'd2) begin
            errors++; $display("FAIL preload_setup: value=%0d expected 2", value);
        end
        value_to_set = 8'd5; set_value = 1'b1;
        tick();
        set_value = 1'b0;
        checks++;
        if (value !== 8'd5 || overflow !== 1'b0) begin
            errors++; $display("FAIL preload_load: value=%0d ovf=%0b expected value=5 ovf=0", value, overflow);
        end
        while (!seen && edges < 20) begin
            tick(); edges++;
            checks++;
            if (value !== W'(m_v) || overflow !== m_ov) begin
                errors++; $display("FAIL preload_run: value=%0d ovf=%0b expected value=%0d ovf=%0b", value, overflow, m_v, m_ov);
            end
            if (overflow) seen = 1'b1;
        end
        checks++;
        if (edges !== 5) begin
            errors++; $display("FAIL preload_latency: overflow after %0d edges expected 5", edges);
        end
    endtask

    task automatic test_load_vs_wrap();
        int guard = 0;
        while (value !== 8'd9 && guard < 20) begin tick(); guard++; end
        checks++;
        if (value !== 8'd9) begin
            errors++; $display("FAIL load_wrap_setup: value=%0d expected 9", value);
        end
        value_to_set = 8'd3; set_value = 1'b1;
        tick();
        set_value = 1'b0;
        checks++;
        if (value !== 8'd3 || overflow !== 1'b0) begin
            errors++; $display("FAIL load_vs_wrap: value=%0d ovf=%0b expected value=3 ovf=0", value, overflow);
        end
    endtask

    task automatic test_out_of_range();
        value_to_set = 8'd200; set_value = 1'b1;
        tick();
        set_value = 1'b0;
        tick();
        checks++;
        if (value !== 8'd0 || overflow !== 1'b1) begin
            errors++; $display("FAIL out_of_range: value=%0d ovf=%0b expected value=0 ovf=1", value, overflow);
        end
        max = 8'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (value !== 8'd0 || overflow !== 1'b1) begin
                errors++; $display("FAIL max_zero: value=%0d ovf=%0b expected value=0 ovf=1", value, overflow);
            end
        end
    endtask

    task automatic test_full_range();
        max = 8'd255; value_to_set = 8'd253; set_value = 1'b1;
        tick();
        set_value = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (value !== W'(m_v) || overflow !== m_ov) begin
                errors++; $display("FAIL full_range: value=%0d ovf=%0b expected value=%0d ovf=%0b", value, overflow, m_v, m_ov);
            end
        end
    endtask

    task automatic test_async_reset();
        max = 8'd9; value_to_set = 8'd0; set_value = 1'b1;
        tick();
        set_value = 1'b0;
        repeat (7) tick();
        checks++;
        if (value !== 8'd7) begin
            errors++; $display("FAIL async_setup: value=%0d expected 7", value);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (value !== 8'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL async_reset: value=%0d ovf=%0b expected value=0 ovf=0", value, overflow);
        end
        @(posedge inc); #1;
        rst_n = 1'b1; m_v = 0; m_ov = 1'b0;
        tick();
        checks++;
        if (value !== 8'd1 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_release: value=%0d ovf=%0b expected value=1 ovf=0", value, overflow);
        end
    endtask

`ifdef MOD_COUNTER_CE_EN
    task automatic test_ce();
        value_to_set = 8'd4; set_value = 1'b1;
        tick();
        set_value = 1'b0; ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (value !== 8'd4 || overflow !== 1'b0) begin
                errors++; $display("FAIL ce_hold: value=%0d ovf=%0b expected value=4 ovf=0", value, overflow);
            end
        end
        value_to_set = 8'd8; set_value = 1'b1;
        tick();
        set_value = 1'b0; ce = 1'b1;
        checks++;
        if (value !== 8'd8) begin
            errors++; $display("FAIL ce_load: value=%0d expected 8", value);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_value    = ($urandom_range(0, 9) == 0);
            value_to_set = W'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) max = W'($urandom_range(0, 20));
`ifdef MOD_COUNTER_CE_EN
            ce = ($urandom_range(0, 3) != 0);
`endif
            tick();
            checks++;
            if (value !== W'(m_v) || overflow !== m_ov) begin
                errors++; $display("FAIL random edge %0d: value=%0d ovf=%0b expected value=%0d ovf=%0b", i, value, overflow, m_v, m_ov);
            end
        end
        set_value = 1'b0; ce = 1'b1;
    endtask

    initial begin
        test_reset();
        test_period();
        test_preload();
        test_load_vs_wrap();
        test_out_of_range();
        test_full_range();
        test_async_reset();
`ifdef MOD_COUNTER_CE_EN
        test_ce();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
